// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu
//  Description : Memory-access pipeline stage. Issues one outstanding
//                request/acknowledge bus transfer per load/store, stalls the
//                pipeline until it completes, and returns aligned,
//                sign/zero-extended load data towards MEM/WB.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [7:0]  mem_aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    input  logic        flush,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        addr_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i
);

    localparam logic [7:0] c_OP_LB  = 8'b1110_0000;
    localparam logic [7:0] c_OP_LBU = 8'b1110_0100;
    localparam logic [7:0] c_OP_LH  = 8'b1110_0001;
    localparam logic [7:0] c_OP_LHU = 8'b1110_0101;
    localparam logic [7:0] c_OP_LW  = 8'b1110_0011;
    localparam logic [7:0] c_OP_SB  = 8'b1110_1000;
    localparam logic [7:0] c_OP_SH  = 8'b1110_1001;
    localparam logic [7:0] c_OP_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_start;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_load_signed;
    logic        w_mem_op;
    logic        w_misaligned;

    logic [3:0]  w_sel;
    logic [31:0] w_store_data;

    logic [31:0] r_rdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    // Decode the operation class, access size and signedness.
    always_comb begin
        w_is_load     = 1'b0;
        w_is_store    = 1'b0;
        w_is_byte     = 1'b0;
        w_is_half     = 1'b0;
        w_load_signed = 1'b0;
        case (mem_aluop_i)
            c_OP_LB:  begin w_is_load  = 1'b1; w_is_byte = 1'b1; w_load_signed = 1'b1; end
            c_OP_LBU: begin w_is_load  = 1'b1; w_is_byte = 1'b1; end
            c_OP_LH:  begin w_is_load  = 1'b1; w_is_half = 1'b1; w_load_signed = 1'b1; end
            c_OP_LHU: begin w_is_load  = 1'b1; w_is_half = 1'b1; end
            c_OP_LW:  begin w_is_load  = 1'b1; end
            c_OP_SB:  begin w_is_store = 1'b1; w_is_byte = 1'b1; end
            c_OP_SH:  begin w_is_store = 1'b1; w_is_half = 1'b1; end
            c_OP_SW:  begin w_is_store = 1'b1; end
            default:  begin end
        endcase
    end

    assign w_mem_op     = w_is_load | w_is_store;
    assign w_misaligned = w_mem_op &&
                          (w_is_half ? mem_addr_i[0] :
                           w_is_byte ? 1'b0 : (mem_addr_i[1:0] != 2'b00));

    // Big-endian byte-lane select and lane-replicated store data.
    always_comb begin
        w_sel        = 4'b1111;
        w_store_data = 32'h0;
        if (w_is_byte) begin
            case (mem_addr_i[1:0])
                2'b00:   w_sel = 4'b1000;
                2'b01:   w_sel = 4'b0100;
                2'b10:   w_sel = 4'b0010;
                default: w_sel = 4'b0001;
            endcase
        end else if (w_is_half) begin
            w_sel = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        end
        if (w_is_store) begin
            if (w_is_byte)      w_store_data = {4{mem_reg2_i[7:0]}};
            else if (w_is_half) w_store_data = {2{mem_reg2_i[15:0]}};
            else                w_store_data = mem_reg2_i;
        end
    end

    // Extract and extend the addressed lane from the latched read word.
    // EX/MEM is held by the stall, so the address is still valid in DONE.
    always_comb begin
        w_byte      = 8'h0;
        w_half      = 16'h0;
        w_load_data = r_rdata;
        case (mem_addr_i[1:0])
            2'b00:   w_byte = r_rdata[31:24];
            2'b01:   w_byte = r_rdata[23:16];
            2'b10:   w_byte = r_rdata[15:8];
            default: w_byte = r_rdata[7:0];
        endcase
        w_half = mem_addr_i[1] ? r_rdata[15:0] : r_rdata[31:16];
        if (w_is_byte)
            w_load_data = w_load_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
        else if (w_is_half)
            w_load_data = w_load_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
    end

    // Next-state logic for the single-outstanding access sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op && !w_misaligned) begin
                    w_state_nxt = S_BUSY;
                    w_start     = 1'b1;
                end
            end
            S_BUSY: begin
                // A flush coinciding with the ack simply drops the result.
                if (bus_ack_i)  w_state_nxt = flush ? S_IDLE : S_DONE;
                else if (flush) w_state_nxt = S_ABORT;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ABORT: begin
                if (bus_ack_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Write-back, stall and exception outputs.
    always_comb begin
        wd_o       = mem_wd_i;
        wreg_o     = mem_wreg_i;
        wdata_o    = mem_wdata_i;
        stallreq_o = 1'b0;
        addr_err_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    wreg_o = 1'b0;
                    if (w_misaligned) addr_err_o = 1'b1;
                    else              stallreq_o = 1'b1;
                end
            end
            S_BUSY, S_ABORT: begin
                wreg_o     = 1'b0;
                stallreq_o = 1'b1;
            end
            S_DONE: begin
                if (w_is_load) wdata_o = w_load_data;
            end
            default: begin end
        endcase
        if (rst) begin
            wd_o       = 5'd0;
            wreg_o     = 1'b0;
            wdata_o    = 32'h0;
            stallreq_o = 1'b0;
            addr_err_o = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Registered bus master: launch on start, retire on ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_o  <= 1'b0;
            bus_we_o   <= 1'b0;
            bus_addr_o <= 32'h0;
            bus_sel_o  <= 4'b0000;
            bus_data_o <= 32'h0;
        end else if (w_start) begin
            bus_req_o  <= 1'b1;
            bus_we_o   <= w_is_store;
            bus_addr_o <= {mem_addr_i[31:2], 2'b00};
            bus_sel_o  <= w_sel;
            bus_data_o <= w_store_data;
        end else if (bus_req_o && bus_ack_i &&
                     (r_state == S_BUSY || r_state == S_ABORT)) begin
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
        end
    end

    // Capture read data only for a transfer that will be written back.
    always_ff @(posedge clk) begin
        if (rst)
            r_rdata <= 32'h0;
        else if (r_state == S_BUSY && bus_ack_i && !flush)
            r_rdata <= bus_data_i;
    end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage sitting directly downstream of the EX/MEM pipeline register. It consumes the registered load/store operation, address and store data. It drives a single-outstanding request/acknowledge data bus and stalls the pipeline until the access completes. It then presents aligned, sign/zero-extended write-back data to the MEM/WB register.

## Interface
Parameters:
- none (bus widths fixed at 32-bit data/address, 8-bit aluop, 5-bit register address)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1)
- mem_wd_i  in  5  destination register from EX/MEM
- mem_wreg_i  in  1  register write enable from EX/MEM
- mem_wdata_i  in  32  ALU result from EX/MEM
- mem_aluop_i  in  8  operation code from EX/MEM
- mem_addr_i  in  32  effective address
- mem_reg2_i  in  32  store data (rt)
- flush  in  1  pipeline flush from control
- wd_o  out  5  destination register to MEM/WB
- wreg_o  out  1  write enable to MEM/WB
- wdata_o  out  32  write-back data to MEM/WB
- stallreq_o  out  1  stall request to control; when high, control drives stall = 6'b011111
- addr_err_o  out  1  misaligned access flag to exception logic
- bus_req_o  out  1  registered bus request
- bus_we_o  out  1  registered write strobe
- bus_addr_o  out  32  registered word address; bits [1:0] forced to 0
- bus_sel_o  out  4  registered byte select; big-endian, bit3 = byte 0
- bus_data_o  out  32  registered store data, replicated into the selected lane(s)
- bus_data_i  in  32  read data, valid when bus_ack_i is high
- bus_ack_i  in  1  transfer complete; sampled only while bus_req_o is high

## Operation
Opcodes:
- LB 8'b11100000, LBU 11100100, LH 11100001, LHU 11100101, LW 11100011
- SB 11101000, SH 11101001, SW 11101011
- All other opcodes are non-memory.

Alignment:
- Misaligned means: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] ≠ 0.
- In IDLE with a misaligned op: addr_err_o = 1, wreg_o = 0, no bus request, no stall, state stays IDLE.

FSM states: IDLE, BUSY, DONE, ABORT.
- IDLE, non-memory op:
  - outputs pass through (wd_o/wreg_o/wdata_o = inputs)
  - stallreq_o = 0
- IDLE, aligned memory op:
  - stallreq_o = 1 (combinational)
  - next edge registers bus_req_o = 1, bus_we_o, bus_addr_o, bus_sel_o, bus_data_o
  - next state BUSY
- BUSY:
  - stallreq_o = 1, wreg_o = 0
  - on bus_ack_i: latch bus_data_i into rdata, drop bus_req_o and bus_we_o, go to DONE
- DONE:
  - stallreq_o = 0
  - loads: wreg_o = mem_wreg_i and wdata_o = extracted rdata
  - stores: wreg_o = mem_wreg_i (0 from EX)
  - next state IDLE unconditionally
- flush while BUSY: go to ABORT.
- ABORT:
  - keep bus_req_o until bus_ack_i, then go to IDLE
  - stallreq_o = 1, wreg_o = 0, read data discarded
- flush in IDLE or DONE: no state effect (EX/MEM delivers a NOP).

Byte lanes (big-endian, addr[1:0]):
- Bytes: 00→sel 1000, data[31:24]; 01→0100, [23:16]; 10→0010, [15:8]; 11→0001, [7:0].
- Halfwords: 00→1100, [31:16]; 10→0011, [15:0].
- Words: sel 1111.
- Store data: SB replicates reg2[7:0] ×4; SH replicates reg2[15:0] ×2.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend.

## Timing
- Reset values:
  - state IDLE
  - bus_req_o, bus_we_o = 0
  - bus_addr_o, bus_data_o, rdata = 0
  - bus_sel_o = 4'b0000
  - stallreq_o, addr_err_o, wreg_o = 0
  - wd_o = 5'b0, wdata_o = 0
- Reset mid-transaction drops the request on that edge; an outstanding ack is then ignored.
- Memory op enters IDLE at cycle N, bus_req_o high from N+1.
  - Ack at cycle N+k (k ≥ 1) → DONE at N+k+1.
  - Minimum stage occupancy is 3 cycles with 2 stall cycles.
- Ack in the same cycle as flush (BUSY) → DONE is skipped; go to IDLE, no write-back.
- The next instruction is evaluated in IDLE on the cycle after DONE, so back-to-back accesses never overlap.
- Non-memory ops add zero latency.

## Test plan
- Reset: assert rst for 2 cycles mid-BUSY → bus_req_o = 0, state IDLE, all outputs 0.
- LB at addr 0x103, bus_data_i = 0x112233F4 with ack 1 cycle after req → bus_sel_o = 0001, stallreq_o high 2 cycles, then wdata_o = 0xFFFFFFF4.
- LHU at 0x102 with data 0x0000ABCD, ack delayed 3 cycles → wdata_o = 0x0000ABCD in DONE; stallreq_o high 4 cycles.
- SB reg2 = 0x000000A5 at 0x201 → bus_we_o = 1, bus_sel_o = 0100, bus_data_o = 0xA5A5A5A5, bus_addr_o = 0x200, wreg_o = 0.
- LW at 0x102 → addr_err_o = 1, bus_req_o stays 0, stallreq_o = 0, wreg_o = 0.
- Flush during BUSY, ack 2 cycles later with 0xDEADBEEF → ABORT holds req, no write-back, IDLE after ack.
